// File: rtl/lsu_bus_if.sv
// Data-bus interface between the load/store bridge and the memory system.
//   bus_req   : request, held high until completion or timeout
//   bus_we    : write strobe qualifying bus_req
//   bus_addr  : word-aligned byte address
//   bus_be    : byte enables
//   bus_wdata : lane-aligned store data
//   bus_ack   : one-cycle completion strobe from the memory system
//   bus_rdata : read word, valid with bus_ack
interface lsu_bus_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_bridge.sv
// Memory-stage load/store unit bridging the pipelined datapath to a
// variable-latency data bus.
//   clk, reset        : clock, synchronous active-high reset
//   addr, wdata       : M-stage byte address and store data
//   we, re            : store / load request (store wins when both set)
//   memcontrol        : funct3 of the access
//   rdata             : sign/zero-extended load data
//   stall             : freeze the pipeline while a transaction is open
//   fault             : sticky illegal/misaligned/timeout flag
//   bus               : master side of lsu_bus_if
module lsu_bus_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic              re,
  input  logic [2:0]        memcontrol,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              fault,
  lsu_bus_if.master         bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Last REQ-cycle count before the timeout fires; unused when TIMEOUT is 0.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       bwdata_q, bwdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [15:0]       cnt_q, cnt_d;

  logic        access, f3_ok, misaligned, legal;
  logic [3:0]  be_new;
  logic [31:0] wd_new, lane, ld_ext;

  assign access = we | re;

  always_comb begin
    if (we) f3_ok = memcontrol inside {3'b000, 3'b001, 3'b010};
    else    f3_ok = memcontrol inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned = ((memcontrol[1:0] == 2'b01) && addr[0]) ||
                 ((memcontrol[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    legal = f3_ok && !misaligned;
  end

  always_comb begin
    be_new = 4'hF;
    wd_new = wdata;
    if (we) begin
      case (memcontrol[1:0])
        2'b00: begin
          be_new = 4'b0001 << addr[1:0];
          wd_new = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_new = 4'b0011 << addr[1:0];
          wd_new = {2{wdata[15:0]}};
        end
        default: begin
          be_new = 4'hF;
          wd_new = wdata;
        end
      endcase
    end
  end

  // Shift the addressed byte/half down to bit 0, then extend by funct3.
  always_comb begin
    lane = bus.bus_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ld_ext = {24'h0, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ld_ext = {16'h0, lane[15:0]};
      default: ld_ext = bus.bus_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    baddr_d  = baddr_q;
    be_d     = be_q;
    bwdata_d = bwdata_q;
    f3_d     = f3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (legal) begin
            req_d    = 1'b1;
            we_d     = we;
            baddr_d  = {addr[ADDR_W-1:2], 2'b00};
            be_d     = be_new;
            bwdata_d = wd_new;
            f3_d     = memcontrol;
            off_d    = addr[1:0];
            cnt_d    = '0;
            state_d  = REQ;
          end else begin
            fault_d = 1'b1;
            rdata_d = '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.bus_ack) begin
          // Stores complete without disturbing the last load result.
          if (!we_q) rdata_d = ld_ext;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          fault_d = 1'b1;
          rdata_d = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= '0;
      be_q     <= '0;
      bwdata_q <= '0;
      f3_q     <= '0;
      off_q    <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      baddr_q  <= baddr_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  // An illegal access reads zero in its own cycle, before rdata_q is cleared.
  assign rdata = ((state_q == IDLE) && access && !legal) ? '0 : rdata_q;
  assign stall = ((state_q == IDLE) && access && legal) || (state_q == REQ);
  assign fault = fault_q;

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = baddr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = bwdata_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Testbench for lsu_bus_bridge: transaction-level reference model, a
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_lsu_bus_bridge;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, stall, fault;
  logic [2:0]  memcontrol;

  lsu_bus_if #(.ADDR_W(32)) bus_if ();

  lsu_bus_bridge #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .memcontrol(memcontrol), .rdata(rdata), .stall(stall), .fault(fault),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // Expected outputs for the current cycle, plus the model's held load result.
  logic        e_stall, e_req, e_we, e_fault;
  logic [31:0] e_addr, e_wdata, e_rdata, m_rdata;
  logic [3:0]  e_be;

  // Observations of the most recent access, for literal checks.
  int          r_stall_cycles, r_req_cycles;
  logic [31:0] r_addr, r_wdata, r_done_rdata;
  logic [3:0]  r_be;
  logic        r_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int acc_bytes(input logic [2:0] f);
    return 1 << (int'(f) % 4);
  endfunction

  function automatic logic is_legal(input logic w, input logic [2:0] f, input logic [31:0] a);
    if (w) begin
      if (f > 3'd2) return 1'b0;
    end else if (f == 3'd3 || f > 3'd5) return 1'b0;
    return (a % 32'(acc_bytes(f))) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic w, input logic [2:0] f, input logic [31:0] a);
    int mask;
    if (!w) return 4'hF;
    mask = (1 << acc_bytes(f)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] model_lane(input logic [2:0] f, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = acc_bytes(f);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_ext(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
    int unsigned v, sz, span;
    sz = acc_bytes(f);
    if (sz == 4) return w;
    span = 1 << (8 * sz);
    v = (w >> (8 * (a % 4))) % span;
    if (f < 3'd4 && v >= span / 2) v = v - span;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall, e_stall);
      chk("bus_req", bus_if.bus_req, e_req);
      chk("fault", fault, e_fault);
      chk("rdata", rdata, e_rdata);
      if (e_req) begin
        chk("bus_we", bus_if.bus_we, e_we);
        chk("bus_addr", bus_if.bus_addr, e_addr);
        chk("bus_be", bus_if.bus_be, e_be);
        chk("bus_wdata", bus_if.bus_wdata, e_wdata);
      end
    end
  end

  task automatic idle_cycle();
    we = 1'b0; re = 1'b0;
    addr = $urandom; wdata = $urandom; memcontrol = 3'($urandom);
    bus_if.bus_ack = 1'($urandom);
    bus_if.bus_rdata = $urandom;
    e_stall = 1'b0; e_req = 1'b0; e_rdata = m_rdata;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  // One access; ack_after = REQ cycle (1-based) carrying bus_ack, 0 = never.
  task automatic access(input logic iwe, input logic ire, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_after, input logic [31:0] brd);
    logic legal, ack;
    legal = is_legal(iwe, f3, a);
    we = iwe; re = ire; memcontrol = f3; addr = a; wdata = wd;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom;
    e_stall = legal; e_req = 1'b0;
    e_rdata = legal ? m_rdata : 32'h0;
    r_stall_cycles = 0; r_req_cycles = 0; r_done_rdata = 'x;
    @(negedge clk);
    r_stall_cycles += int'(stall); r_req_cycles += int'(bus_if.bus_req);
    @(posedge clk); #1;
    if (!legal) begin
      e_fault = 1'b1;
      m_rdata = '0;
      idle_cycle();
      return;
    end
    for (int j = 0; ; j++) begin
      ack = (j == ack_after - 1);
      bus_if.bus_ack = ack;
      bus_if.bus_rdata = ack ? brd : $urandom;
      e_stall = 1'b1; e_req = 1'b1; e_we = iwe;
      e_addr = a - (a % 4); e_be = model_be(iwe, f3, a);
      e_wdata = iwe ? model_lane(f3, wd) : 32'h0;
      if (!iwe) e_wdata = bus_if.bus_wdata; // store data is don't-care on loads
      e_rdata = m_rdata;
      @(negedge clk);
      r_stall_cycles += int'(stall); r_req_cycles += int'(bus_if.bus_req);
      if (j == 0) begin
        r_addr = bus_if.bus_addr; r_be = bus_if.bus_be;
        r_wdata = bus_if.bus_wdata; r_we = bus_if.bus_we;
      end
      @(posedge clk); #1;
      if (ack) begin
        if (!iwe) m_rdata = model_ext(f3, a, brd);
        break;
      end
      if (j == int'(TO) - 1) begin
        m_rdata = '0;
        e_fault = 1'b1;
        break;
      end
    end
    // DONE: the bridge must ignore whatever the datapath and bus present.
    we = 1'($urandom); re = 1'($urandom); memcontrol = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    bus_if.bus_ack = 1'($urandom); bus_if.bus_rdata = $urandom;
    e_stall = 1'b0; e_req = 1'b0; e_rdata = m_rdata;
    @(negedge clk);
    r_done_rdata = rdata;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; memcontrol = '0; addr = '0; wdata = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_fault = 1'b0;
    e_addr = '0; e_wdata = '0; e_be = '0; e_rdata = '0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_bus_req", bus_if.bus_req, 1'b0);
    chk("rst_bus_we", bus_if.bus_we, 1'b0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst_bus_be", bus_if.bus_be, 4'h0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    chk_en = 1'b1;

    access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    chk("lw_stall_cycles", r_stall_cycles, 4);
    chk("lw_bus_addr", r_addr, 32'h100);
    chk("lw_bus_be", r_be, 4'hF);
    chk("lw_done_rdata", r_done_rdata, 32'hDEADBEEF);

    access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);
    chk("lb_rdata", r_done_rdata, 32'hFFFFFF80);
    chk("lb_stall_cycles", r_stall_cycles, 2);
    access(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);
    chk("lbu_rdata", r_done_rdata, 32'h00000080);
    access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 2, 32'h80112233);
    chk("lh_rdata", r_done_rdata, 32'hFFFF8011);
    idle_cycle();
    chk("rdata_hold_idle", rdata, 32'hFFFF8011);

    access(1'b1, 1'b0, 3'b000, 32'h201, 32'h000000AB, 1, 32'h0);
    chk("sb_bus_addr", r_addr, 32'h200);
    chk("sb_bus_be", r_be, 4'b0010);
    chk("sb_bus_wdata", r_wdata, 32'hABABABAB);
    chk("sb_bus_we", r_we, 1'b1);
    access(1'b1, 1'b0, 3'b001, 32'h202, 32'h1234CDEF, 2, 32'h0);
    chk("sh_bus_be", r_be, 4'b1100);
    chk("sh_bus_wdata", r_wdata, 32'hCDEFCDEF);

    access(1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 1, 32'h12345678);
    chk("mis_stall_cycles", r_stall_cycles, 0);
    chk("mis_req_cycles", r_req_cycles, 0);
    chk("mis_fault", fault, 1'b1);
    access(1'b0, 1'b1, 3'b010, 32'h104, 32'h0, 1, 32'h0BADF00D);
    chk("fault_sticky", fault, 1'b1);
    chk("after_fault_rdata", r_done_rdata, 32'h0BADF00D);

    access(1'b0, 1'b1, 3'b010, 32'h180, 32'h0, 0, 32'h0);
    chk("to_req_cycles", r_req_cycles, 4);
    chk("to_done_rdata", r_done_rdata, 32'h0);

    for (int t = 0; t < 300; t++) begin
      logic iw;
      iw = 1'($urandom);
      access(iw, iw ? 1'($urandom) : 1'b1, 3'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 6)), $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    // Reset in the middle of an open load; a late ack must not land.
    chk_en = 1'b0;
    we = 1'b0; re = 1'b1; memcontrol = 3'b010; addr = 32'h300;
    bus_if.bus_ack = 1'b0;
    @(posedge clk); #1;
    re = 1'b0;
    @(negedge clk);
    chk("mid_req_open", bus_if.bus_req, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", bus_if.bus_req, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_fault", fault, 1'b0);
    chk("mid_rst_rdata", rdata, 32'h0);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_rdata", rdata, 32'h0);
    chk("late_ack_req", bus_if.bus_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Memory-stage load/store unit between the pipelined datapath and a variable-latency data bus.
- Takes the M-stage address, store data, write enable and funct3 (memcontrol) from the datapath, and drives the bus with byte enables and lane-replicated store data.
- Returns sign- or zero-extended load data to the datapath.
- Raises stall while a bus transaction is outstanding, so the datapath freezes its pipeline until the transaction completes.

Parameters:
- TIMEOUT, 16, bus-ack wait limit in cycles; 0 disables the timeout.
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- addr  input  ADDR_W  M-stage byte address (datapath aluout)
- wdata  input  32  M-stage store data (datapath writedata)
- we  input  1  store request (datapath memWE)
- re  input  1  load request (M-stage memtoreg)
- memcontrol  input  3  funct3 of the access
- rdata  output  32  extended load data to the datapath readdata
- stall  output  1  hold the pipeline
- fault  output  1  sticky error flag
- bus_req  output  1  bus request
- bus_we  output  1  bus write
- bus_addr  output  ADDR_W  word-aligned bus address (low 2 bits are 0)
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-aligned store data
- bus_ack  input  1  one-cycle completion strobe
- bus_rdata  input  32  read word, valid with bus_ack

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata = 0; rdata = 0; fault = 0; timeout counter = 0.
- Reset asserted mid-transaction: bus_req falls on the next edge and any later bus_ack is ignored.
- Access = we | re. If both are high, the access is a store.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010 only.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0.
- Illegal or misaligned access:
  - No bus activity; fault set (sticky until reset); stall = 0; rdata = 0 for that access.
  - The FSM stays in IDLE.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On a legal access: stall = 1 combinationally in the same cycle.
  - At the edge: latch word address, byte enables, lane data, funct3 and addr[1:0]; set bus_req = 1 and bus_we = we; go to REQ.
- REQ:
  - bus_req and all bus outputs held stable; stall = 1; counter increments each cycle.
  - On bus_ack: register the extended bus_rdata into rdata; drop bus_req; go to DONE.
  - If TIMEOUT ≠ 0 and the counter reaches TIMEOUT-1 without ack: set fault, rdata = 0, drop bus_req, go to DONE.
- DONE (one cycle):
  - stall = 0 so the pipeline advances; rdata holds the result.
  - Inputs are ignored, because the same instruction is still presented. Next state IDLE.
- Latency: a load with ack in the first REQ cycle costs two stall cycles, and data is valid in the DONE cycle.
- Store lanes:
  - SB: bus_be = 0001 << addr[1:0]; bus_wdata = {4{wdata[7:0]}}.
  - SH: bus_be = 0011 << addr[1:0]; bus_wdata = {2{wdata[15:0]}}.
  - SW: bus_be = 1111; bus_wdata = wdata.
- Loads: bus_be = 1111. Byte/half is selected with the latched addr[1:0], then sign-extended for LB/LH and zero-extended for LBU/LHU.
- bus_ack outside REQ is ignored.
- rdata holds its value in IDLE until the next load completes.

Test Plan:
- LW addr=0x100, ack after 3 cycles, bus_rdata=0xDEADBEEF -> bus_addr=0x100, be=1111; stall high 4 cycles; rdata=0xDEADBEEF in DONE.
- LB addr=0x103, bus_rdata=0x80112233 -> rdata=0xFFFFFF80; same with LBU -> 0x00000080; LH addr=0x102 -> 0xFFFF8011.
- SB addr=0x201, wdata=0x000000AB -> bus_addr=0x200, be=0010, bus_wdata=0xABABABAB, bus_we=1; SH addr=0x202 -> be=1100.
- LW addr=0x102 -> no bus_req, stall=0, fault=1 and stays 1 after later legal accesses until reset.
- TIMEOUT=4, no ack -> bus_req high exactly 4 cycles, fault=1, rdata=0, then DONE, then IDLE.
- Reset pulsed while in REQ -> next cycle bus_req=0, stall=0, fault=0; a late bus_ack is ignored and rdata stays 0.
